// File: rtl/sobel_window_buffer.sv
// -----------------------------------------------------------------------------
// sobel_window_buffer
//
// Queues 4x4 tiles of PIX_W-bit pixels coming from the AHB slave side and hands
// the four overlapping 3x3 windows of each tile, one at a time, to the Sobel
// gradient core.
//
// Ports:
//   HCLK, HRESETn  clock (rising edge) and asynchronous active-low reset
//   pixels         4x4 tile, pixel (r,c) at [(r*4+c)*PIX_W +: PIX_W]
//   load_enable    single-cycle pulse: push pixels into the tile FIFO
//   window         3x3 window, element (i,j) at [(i*3+j)*PIX_W +: PIX_W]
//   window_valid   window / window_idx / tile_last are valid
//   window_ready   consumer accepts the current window
//   window_idx     window position in tile, {row offset, col offset}
//   tile_last      current window is the last (idx 3) of its tile
//   full           FIFO holds DEPTH tiles
//   overflow       sticky: a load arrived while full and was dropped
//   tiles_done     number of tiles fully emitted (wraps at 16 bits)
//
// Handshake (window_valid / window_ready): a window transfers on a rising HCLK
// edge where both are high. While valid is high and no transfer happens,
// window, window_idx and tile_last hold stable. Valid never depends on ready,
// and the consumer may hold ready high permanently.
// -----------------------------------------------------------------------------
module sobel_window_buffer #(
  parameter int PIX_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [16*PIX_W-1:0]  pixels,
  input  logic                 load_enable,
  output logic [9*PIX_W-1:0]   window,
  output logic                 window_valid,
  input  logic                 window_ready,
  output logic [1:0]           window_idx,
  output logic                 tile_last,
  output logic                 full,
  output logic                 overflow,
  output logic [15:0]          tiles_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Tile storage carries no reset; validity is tracked purely by count.
  logic [16*PIX_W-1:0] mem [DEPTH];
  logic [16*PIX_W-1:0] head;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic xfer;
  logic pop;
  logic push_ok;
  logic drop;

  assign head         = mem[rd_ptr];
  assign window_valid = (count != '0);
  assign full         = (count == DEPTH_C);
  assign tile_last    = window_valid && (window_idx == 2'd3);

  assign xfer = window_valid && window_ready;
  assign pop  = xfer && (window_idx == 2'd3);

  // A full FIFO still accepts a load in the same cycle its head tile retires,
  // because the retiring slot is freed by that same edge.
  assign push_ok = load_enable && (!full || pop);
  assign drop    = load_enable && !push_ok;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Window extraction: window_idx selects the top-left corner (r0,c0) of the
  // 3x3 sub-block inside the head tile.
  always_comb begin
    int r0;
    int c0;
    window = '0;
    r0 = int'(window_idx[1]);
    c0 = int'(window_idx[0]);
    if (window_valid) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          window[(i*3+j)*PIX_W +: PIX_W] = head[((r0+i)*4 + (c0+j))*PIX_W +: PIX_W];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= pixels;
    end
  end

  // Pointers are log2(DEPTH) bits wide, so natural overflow wraps them.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      window_idx <= 2'd0;
      overflow   <= 1'b0;
      tiles_done <= 16'd0;
    end else begin
      count <= count_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        tiles_done <= tiles_done + 16'd1;
      end
      // idx 3 + 1 wraps to 0, which is exactly the start of the next tile.
      if (xfer) begin
        window_idx <= window_idx + 2'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sobel_window_buffer.md
Name: sobel_window_buffer

Overview:
- Sits directly downstream of the AHB slave interface of the Sobel edge detector.
- Captures each 4x4 tile of 4-bit pixels when `load_enable` pulses, and queues up to DEPTH tiles.
- Emits the four overlapping 3x3 windows of each tile, one per handshake, to the Sobel gradient core.
- Provides full, overflow and tile-count status to the bus side.

Parameters:
- PIX_W, 4, bits per pixel.
- DEPTH, 2, tile FIFO entries (power of two, >=2).

Ports:
- HCLK  input  1  system clock, rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- pixels  input  16*PIX_W  tile; pixel (r,c) at bits [(r*4+c)*PIX_W +: PIX_W], r,c in 0..3.
- load_enable  input  1  single-cycle pulse; push pixels into FIFO.
- window  output  9*PIX_W  3x3 window; element (i,j) at bits [(i*3+j)*PIX_W +: PIX_W].
- window_valid  output  1  window/window_idx valid.
- window_ready  input  1  consumer accepts window this cycle.
- window_idx  output  2  window position within tile: {row offset, col offset}.
- tile_last  output  1  high with window_valid when window_idx==3.
- full  output  1  FIFO holds DEPTH tiles.
- overflow  output  1  sticky: a load was dropped.
- tiles_done  output  16  count of fully emitted tiles, wraps at 65535->0.

Behaviour:
- Reset (async, HRESETn low) clears:
  - FIFO pointers and occupancy count.
  - window_idx=0, window_valid=0, tile_last=0, full=0, overflow=0, tiles_done=0.
  - window=0.
- Reset mid-tile discards all queued tiles and the partial emission. No window is presented until a new load_enable after reset deasserts.
- FIFO storage:
  - DEPTH x 16*PIX_W registers, with write pointer, read pointer and count (0..DEPTH).
  - Storage need not be reset.
- Push: on a rising HCLK edge with load_enable=1, the tile is written at the write pointer.
  - Accepted if count<DEPTH, or if count==DEPTH and a pop occurs the same cycle.
  - Otherwise the tile is dropped, overflow is set to 1 (stays 1 until reset), and count and pointers are unchanged.
- Emission:
  - window_valid = (count!=0).
  - window is combinational from the head entry and window_idx: r0=window_idx[1], c0=window_idx[0], element (i,j) = head pixel (r0+i, c0+j).
  - When window_valid=0, window=0.
- Handshake:
  - Transfer occurs when window_valid && window_ready.
  - On transfer with window_idx<3: window_idx increments.
  - On transfer with window_idx==3 (pop): window_idx returns to 0, the read pointer advances, count decrements, and tiles_done increments.
  - Without a transfer, window, window_valid and window_idx hold stable.
  - The consumer may hold window_ready high continuously.
- Windows per tile are emitted in strict order 0,1,2,3.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Next tile already queued at pop: its window 0 is valid the following cycle, with no bubble.
- Latency: load_enable at edge N into an empty FIFO gives window_valid=1, window_idx=0 after edge N.
- With window_ready held high, the tile's four windows occupy cycles N+1..N+4, and count returns to 0 after edge N+4.
- Pointers wrap modulo DEPTH.
- full = (count==DEPTH), registered-state derived.
- tile_last = window_valid && (window_idx==3).

Test Plan:
- Reset, then load tile with pixel(r,c)=r*4+c, window_ready=1 -> windows 36'hA98654210, 36'hBA9765321, 36'hEDCA98654, 36'hFEDBA9765 on consecutive cycles with idx 0..3 and tile_last on the 4th; tiles_done=1; window_valid=0 afterwards.
- Same tile, window_ready=0 for 5 cycles then 1 -> window 36'hA98654210 and idx 0 held stable; all four windows are emitted after ready rises.
- Three loads back-to-back with window_ready=0 -> full=1 after 2nd load, 3rd load dropped, overflow=1; then ready=1 -> exactly 8 windows, tiles_done=2, overflow remains 1.
- FIFO full and a 3rd load pulse coincident with the idx-3 transfer -> load accepted, overflow stays 0, full stays 1, the next tile's window 0 is valid the next cycle.
- Continuous loads every 4 cycles with ready=1 -> window_valid never drops, tiles_done increments every 4 cycles, no overflow.
- Assert HRESETn low mid-tile with idx=2 and 1 tile queued -> all outputs return to reset values asynchronously; no windows appear after release until a new load_enable.
